// File: rtl/ctx_save_restore.sv
// rtl/ctx_save_restore.sv - register-file context save/restore engine
//
// Save (mode=0): reads registers 0..NREGS-1 through rf_raddr/rf_rdata and
// writes each to memory at base + 4*index.
// Restore (mode=1): reads memory at base + 4*index and writes each value
// back through rf_waddr/rf_wdata/rf_we.
//
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   start, mode, base_addr  transfer request; mode/base sampled with start
//   busy, done            transfer in progress / one-cycle completion pulse
//   rf_raddr, rf_rdata    register-file read port (combinational read)
//   rf_waddr, rf_wdata, rf_we  register-file write port
//   mem_req, mem_we, mem_addr, mem_wdata  memory request, held until mem_ack
//   mem_rdata, mem_ack    memory response
module ctx_save_restore #(
    parameter int NREGS = 32,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done,
    output logic [4:0]    rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic [4:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_we,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [2:0] {
        IDLE,
        S_RD,
        S_MEM,
        R_MEM,
        R_WR,
        DONE
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [AW-1:0] base_q, base_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;

    logic          last_idx;
    logic [AW-1:0] frame_addr;

    assign last_idx   = (idx_q == LAST_IDX);
    // Wraps modulo 2^AW; base low bits are used as given.
    assign frame_addr = base_q + AW'({idx_q, 2'b00});

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            mem_wdata_q <= '0;
            rf_wdata_q  <= '0;
            rf_waddr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            mem_wdata_q <= mem_wdata_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_waddr_q  <= rf_waddr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        mem_wdata_d = mem_wdata_q;
        rf_wdata_d  = rf_wdata_q;
        rf_waddr_d  = rf_waddr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    base_d  = base_addr;
                    // The transfer direction is carried by the state path.
                    state_d = mode ? R_MEM : S_RD;
                end
            end
            S_RD: begin
                mem_wdata_d = rf_rdata;
                state_d     = S_MEM;
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_RD;
                    end
                end
            end
            R_MEM: begin
                if (mem_ack) begin
                    rf_wdata_d = mem_rdata;
                    rf_waddr_d = idx_q;
                    state_d    = R_WR;
                end
            end
            R_WR: begin
                if (last_idx) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = R_MEM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state so an async reset clears them
    // in the same instant.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rf_raddr = '0;
        rf_we    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        case (state_q)
            S_RD: begin
                busy     = 1'b1;
                rf_raddr = idx_q;
            end
            S_MEM: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = frame_addr;
            end
            R_MEM: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = frame_addr;
            end
            R_WR: begin
                busy  = 1'b1;
                rf_we = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/ctx_save_restore.md
Name: ctx_save_restore

Overview:
- Context save/restore engine: the other end of the 32x32 register file port.
- Save: reads every register through one register-file read port and streams each value to memory.
- Restore: fetches values from memory and writes them back through the register-file write port.
- Sits between the core's register file and the data-memory/cache port. The OS context-switch sequencer triggers it to swap register state on a task switch.

Parameters:
- NREGS, 32, number of registers transferred (indices 0..NREGS-1, register 0 included).
- AW, 32, memory address width.
- DW, 32, data width (register and memory word).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; ignored while busy=1.
- mode  in  1  0 = save (regfile -> memory), 1 = restore (memory -> regfile); sampled with start.
- base_addr  in  AW  memory base of the context frame; sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse when the last register is transferred.
- rf_raddr  out  5  register-file read address.
- rf_rdata  in  DW  register-file read data (combinational from rf_raddr).
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  DW  register-file write data.
- rf_we  out  1  register-file write enable, one cycle per register.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write (save), 0 = read (restore); valid while mem_req=1.
- mem_addr  out  AW  word address = base + 4*index.
- mem_wdata  out  DW  write data, stable while mem_req=1.
- mem_rdata  in  DW  read data, valid in the mem_ack cycle.
- mem_ack  in  1  completes the current request at the rising edge where mem_req=mem_ack=1.

Behaviour:
- Reset (async): state IDLE, index 0. All outputs 0: busy, done, rf_raddr, rf_waddr, rf_wdata, rf_we, mem_req, mem_we, mem_addr, mem_wdata.
- Reset mid-transfer aborts immediately. No further rf_we or mem_req is issued; partial memory/regfile contents stay as left.
- States: IDLE, S_RD, S_MEM, R_MEM, R_WR, DONE.
- IDLE:
  - On start=1: latch mode and base_addr, clear index, set busy=1.
  - Next state is S_RD if mode=0, R_MEM if mode=1.
- S_RD:
  - rf_raddr = index.
  - One settle cycle, then capture rf_rdata into mem_wdata at the edge and go to S_MEM.
- S_MEM:
  - mem_req=1, mem_we=1, mem_addr = base + {index,2'b00}.
  - Hold all mem_* stable until mem_ack.
  - On ack: if index = NREGS-1 go to DONE, else index+1 and go to S_RD.
- R_MEM:
  - mem_req=1, mem_we=0, mem_addr as above.
  - On ack: capture mem_rdata into rf_wdata, set rf_waddr = index, go to R_WR.
- R_WR:
  - rf_we=1 for exactly one cycle.
  - Then, if index = NREGS-1 go to DONE, else index+1 and go to R_MEM.
- DONE: done=1 for one cycle, busy=0 in the same cycle; go to IDLE.
- A start coincident with DONE is ignored. A new start is accepted in IDLE only.
- Outputs outside their active state:
  - mem_req=0 and rf_we=0.
  - mem_ack while mem_req=0 is ignored.
- Address arithmetic is modulo 2^AW. A base near the top of memory wraps to 0 without error. base_addr low bits are used as given, with no alignment check.
- Latency with zero-wait memory (ack in the first req cycle): 2 cycles per register. A full 32-register save or restore is 64 cycles plus 1 DONE cycle, after the start cycle. Each memory wait cycle adds 1.
- Order: ascending index 0..NREGS-1.
- Exactly one rf_we pulse per restored register, and exactly one accepted mem write per saved register.

Test Plan:
- Save, zero-wait: preload reg[i]=0xA000_0000+i, base=0x0000_1000, mode=0. Required: 32 writes, addr 0x1000+4i, data 0xA000_0000+i; done on cycle 65 after start; busy low with done.
- Restore, 2-wait-cycle ack: memory word 0x2000+4i = ~i, base=0x2000, mode=1. Required: reg[i] = ~i for all 32; exactly 32 rf_we pulses; mem_addr/mem_we stable during waits.
- Round trip: save with base=0x3000, clobber all regs to 0, restore from 0x3000. Required: all 32 registers equal their original values.
- Wrap and ignored start: base=0xFFFF_FFF0 save. Required: register 4 at address 0x0000_0000, register 5 at 0x0000_0004. A start pulse mid-transfer causes no restart (index continues).
- Reset mid-restore: assert RESET during R_WR of index 10. Required: rf_we, mem_req, busy, done go to 0 immediately; regs 0..9 restored, reg 10 not written; a fresh start afterwards runs a complete transfer from index 0.
